// File: rtl/elelock_pkg.sv
// Shared types and constants for the electronic ten-key lock.
package elelock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_LOCKED,
    ST_LOCKOUT
  } state_e;

endpackage

// File: rtl/elelock_gen_tenkey_if.sv
// Ten-key front end: rising-edge detect on any key, then one-hot to digit encode.
module tenkey_if
  import elelock_pkg::*;
(
  input  logic               ck,
  input  logic               reset,
  input  logic [9:0]         tenkey,
  output logic               key_valid,
  output logic [DIGIT_W-1:0] key_digit
);

  // sync_q[0] is the newer sample, sync_q[1] the older one
  logic [1:0] sync_q, sync_d;
  logic [3:0] ones;

  always_comb begin
    sync_d = {sync_q[0], |tenkey};
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  always_comb begin
    ones      = '0;
    key_digit = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (tenkey[i]) begin
        ones      = ones + 4'd1;
        key_digit = 4'(i);
      end
    end
    key_valid = sync_q[0] & ~sync_q[1] & (ones == 4'd1);
  end

endmodule

// File: rtl/elelock_gen.sv
// Electronic lock: registers a code on close, unlocks on a matching entry,
// and locks out for a fixed time after too many consecutive wrong codes.
module elelock_gen
  import elelock_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 1000
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       alarm,
  output logic [3:0] fail_cnt,
  output logic [3:0] digit_cnt
);

  localparam logic [3:0]  DIGITS_C   = 4'(DIGITS);
  localparam logic [3:0]  MAX_FAIL_C = 4'(MAX_FAIL);
  localparam logic [19:0] LOCK_LOAD  = 20'(LOCKOUT_CYC - 1);

  typedef logic [DIGITS-1:0][DIGIT_W-1:0] code_t;

  state_e      state_q, state_d;
  logic        lock_q, lock_d;
  logic        alarm_q, alarm_d;
  logic [3:0]  fail_q, fail_d;
  logic [3:0]  dcnt_q, dcnt_d;
  code_t       key_q, key_d;
  code_t       secret_q, secret_d;
  logic [19:0] lo_cnt_q, lo_cnt_d;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic [3:0]         fail_inc;
  logic               full;

  tenkey_if u_tenkey (
    .ck        (ck),
    .reset     (reset),
    .tenkey    (tenkey),
    .key_valid (key_valid),
    .key_digit (key_digit)
  );

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    alarm_d  = alarm_q;
    fail_d   = fail_q;
    dcnt_d   = dcnt_q;
    key_d    = key_q;
    secret_d = secret_q;
    lo_cnt_d = lo_cnt_q;
    fail_inc = fail_q + 4'd1;
    full     = (dcnt_q == DIGITS_C);

    unique case (state_q)
      ST_OPEN: begin
        // close wins over a simultaneous press, even when it is ignored
        if (close) begin
          if (full) begin
            secret_d = key_q;
            key_d    = {DIGITS{BLANK}};
            dcnt_d   = '0;
            state_d  = ST_LOCKED;
            lock_d   = 1'b1;
          end
        end else if (key_valid) begin
          key_d = {key_q[DIGITS-2:0], key_digit};
          if (!full) dcnt_d = dcnt_q + 4'd1;
        end
      end

      ST_LOCKED: begin
        // a full buffer means this is the evaluation cycle; presses are dropped
        if (full) begin
          key_d  = {DIGITS{BLANK}};
          dcnt_d = '0;
          if (key_q == secret_q) begin
            fail_d  = '0;
            state_d = ST_OPEN;
            lock_d  = 1'b0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == MAX_FAIL_C) begin
              state_d  = ST_LOCKOUT;
              alarm_d  = 1'b1;
              lo_cnt_d = LOCK_LOAD;
            end
          end
        end else if (key_valid) begin
          key_d  = {key_q[DIGITS-2:0], key_digit};
          dcnt_d = dcnt_q + 4'd1;
        end
      end

      ST_LOCKOUT: begin
        if (lo_cnt_q == '0) begin
          state_d = ST_LOCKED;
          alarm_d = 1'b0;
          fail_d  = '0;
        end else begin
          lo_cnt_d = lo_cnt_q - 20'd1;
        end
      end

      default: begin
        state_d = ST_OPEN;
        lock_d  = 1'b0;
        alarm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q  <= ST_OPEN;
      lock_q   <= 1'b0;
      alarm_q  <= 1'b0;
      fail_q   <= '0;
      dcnt_q   <= '0;
      key_q    <= {DIGITS{BLANK}};
      secret_q <= {DIGITS{BLANK}};
      lo_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      alarm_q  <= alarm_d;
      fail_q   <= fail_d;
      dcnt_q   <= dcnt_d;
      key_q    <= key_d;
      secret_q <= secret_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  assign lock      = lock_q;
  assign alarm     = alarm_q;
  assign fail_cnt  = fail_q;
  assign digit_cnt = dcnt_q;

endmodule
